// File: rtl/ads41_delay_cal.sv
// ADS41 IDELAY calibration: sweeps one shared tap over every data lane, keeps each lane's widest
// passing window and loads its centre. Define ADS41_CAL_OVR_EN to also strobe/load each channel's OVR lane.
module ads41_delay_cal #(
  parameter int               NCHANS   = 2,
  parameter int               NBITS    = 12,
  parameter logic [NBITS-1:0] EXPECT   = 12'hAAA,
  parameter int               NTAPS    = 32,
  parameter int               SETTLE   = 16,
  parameter int               NSAMPLES = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [NCHANS*NBITS-1:0]   d_in,
  output logic [4:0]                idelay_val,
  output logic [NCHANS*16-1:0]      idelay_ld,
  output logic                      busy,
  output logic                      done,
  output logic                      fail,
  input  logic [7:0]                lane_sel,
  output logic [4:0]                lane_center,
  output logic [5:0]                lane_width
);
  localparam int L      = NBITS / 2;
  localparam int NLANES = NCHANS * L;
`ifdef ADS41_CAL_OVR_EN
  localparam int LAST_SUB = L;
`else
  localparam int LAST_SUB = L - 1;
`endif

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_SAMPLE, S_NEXT, S_APPLY, S_DONE} state_t;
  state_t state_reg, state_next;

  logic [4:0]        tap_reg;
  logic [15:0]       cnt_reg;
  logic [7:0]        apply_ch_reg;
  logic [7:0]        apply_sub_reg;
  logic              fail_reg;
  logic [NLANES-1:0] pass_reg;
  logic [NLANES-1:0] lane_ok;
  logic [4:0]        cur_start_reg  [NLANES];
  logic [5:0]        cur_len_reg    [NLANES];
  logic [4:0]        best_start_reg [NLANES];
  logic [5:0]        best_len_reg   [NLANES];
  logic [4:0]        center_w       [NLANES];
  logic [7:0]        apply_lane;
  logic [4:0]        apply_center;
  logic [5:0]        apply_len;
  logic              apply_last;

  genvar gi, gj;
  generate
    for (gi = 0; gi < NCHANS; gi++) begin : g_ch
      for (gj = 0; gj < L; gj++) begin : g_lane
        assign lane_ok[gi*L+gj] = (d_in[gi*NBITS+2*gj +: 2] == EXPECT[2*gj +: 2]);
      end
    end
    for (gi = 0; gi < NLANES; gi++) begin : g_center
      assign center_w[gi] = best_start_reg[gi] + 5'(best_len_reg[gi] >> 1);
    end
  endgenerate

  // The OVR slot (sub == L) reuses the channel's lane-0 result.
  assign apply_lane = 8'(apply_ch_reg * 8'(L)) + ((apply_sub_reg >= 8'(L)) ? 8'd0 : apply_sub_reg);
  assign apply_last = (apply_ch_reg == 8'(NCHANS-1)) && (apply_sub_reg == 8'(LAST_SUB));
  assign fail       = fail_reg;

  always_comb begin
    lane_center  = 5'd0;
    lane_width   = 6'd0;
    apply_center = 5'd0;
    apply_len    = 6'd0;
    for (int l = 0; l < NLANES; l++) begin
      if (lane_sel == 8'(l)) begin
        lane_center = center_w[l];
        lane_width  = best_len_reg[l];
      end
      if (apply_lane == 8'(l)) begin
        apply_center = center_w[l];
        apply_len    = best_len_reg[l];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    idelay_val = 5'd0;
    idelay_ld  = '0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_next = S_LOAD;
      end
      S_LOAD: begin
        idelay_val = tap_reg;
        for (int c = 0; c < NCHANS; c++)
          for (int b = 0; b <= LAST_SUB; b++)
            idelay_ld[c*16+b] = 1'b1;
        state_next = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
      end
      S_SETTLE: if (cnt_reg == 16'(SETTLE-1)) state_next = S_SAMPLE;
      S_SAMPLE: if (cnt_reg == 16'(NSAMPLES-1)) state_next = S_NEXT;
      S_NEXT:   state_next = (tap_reg == 5'(NTAPS-1)) ? S_APPLY : S_LOAD;
      S_APPLY: begin
        idelay_val = apply_center;
        for (int c = 0; c < NCHANS; c++)
          for (int b = 0; b <= LAST_SUB; b++)
            if (apply_ch_reg == 8'(c) && apply_sub_reg == 8'(b)) idelay_ld[c*16+b] = 1'b1;
        if (apply_last) state_next = S_DONE;
      end
      S_DONE: begin
        busy       = 1'b0;
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap_reg       <= 5'd0;
      cnt_reg       <= 16'd0;
      apply_ch_reg  <= 8'd0;
      apply_sub_reg <= 8'd0;
      fail_reg      <= 1'b0;
      pass_reg      <= '0;
      for (int l = 0; l < NLANES; l++) begin
        cur_start_reg[l]  <= 5'd0;
        cur_len_reg[l]    <= 6'd0;
        best_start_reg[l] <= 5'd0;
        best_len_reg[l]   <= 6'd0;
      end
    end else begin
      case (state_reg)
        S_IDLE: if (start) begin
          tap_reg       <= 5'd0;
          cnt_reg       <= 16'd0;
          apply_ch_reg  <= 8'd0;
          apply_sub_reg <= 8'd0;
          fail_reg      <= 1'b0;
          for (int l = 0; l < NLANES; l++) begin
            cur_start_reg[l]  <= 5'd0;
            cur_len_reg[l]    <= 6'd0;
            best_start_reg[l] <= 5'd0;
            best_len_reg[l]   <= 6'd0;
          end
        end
        S_LOAD: begin
          cnt_reg  <= 16'd0;
          pass_reg <= '1;
        end
        S_SETTLE: cnt_reg <= (cnt_reg == 16'(SETTLE-1)) ? 16'd0 : cnt_reg + 16'd1;
        S_SAMPLE: begin
          cnt_reg  <= cnt_reg + 16'd1;
          pass_reg <= pass_reg & lane_ok;
        end
        S_NEXT: begin
          tap_reg <= tap_reg + 5'd1;
          // Strict '>' keeps the earliest of equally wide windows.
          for (int l = 0; l < NLANES; l++) begin
            if (pass_reg[l]) begin
              if (cur_len_reg[l] == 6'd0) cur_start_reg[l] <= tap_reg;
              cur_len_reg[l] <= cur_len_reg[l] + 6'd1;
              if (cur_len_reg[l] + 6'd1 > best_len_reg[l]) begin
                best_start_reg[l] <= (cur_len_reg[l] == 6'd0) ? tap_reg : cur_start_reg[l];
                best_len_reg[l]   <= cur_len_reg[l] + 6'd1;
              end
            end else begin
              cur_len_reg[l] <= 6'd0;
            end
          end
        end
        S_APPLY: begin
          if (apply_len == 6'd0) fail_reg <= 1'b1;
          if (apply_sub_reg == 8'(LAST_SUB)) begin
            apply_sub_reg <= 8'd0;
            apply_ch_reg  <= apply_ch_reg + 8'd1;
          end else begin
            apply_sub_reg <= apply_sub_reg + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
